// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit:
// branch opcodes, 2-bit BHT counter encoding, branch decode helper.
package branch_pkg;

  localparam logic [5:0] OP_BEQ = 6'b001000;
  localparam logic [5:0] OP_BNE = 6'b001001;
  localparam logic [5:0] OP_BGT = 6'b001010;
  localparam logic [5:0] OP_BGE = 6'b001011;
  localparam logic [5:0] OP_BLT = 6'b001100;
  localparam logic [5:0] OP_BLE = 6'b001101;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  localparam bht_cnt_t BHT_RST = WNT;

  function automatic logic is_branch(
    input logic [5:0] op
  );
    logic r;
    r = 1'b0;
    case (op)
      OP_BEQ, OP_BNE, OP_BGT,
      OP_BGE, OP_BLT, OP_BLE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht_table.sv
// Branch history table: DEPTH x 2-bit saturating counters.
// Ports: clk, rst (sync, high); rd_idx -> rd_state (async read);
//        upd_en/upd_idx/upd_taken sync saturating update.
module bht_table
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_state,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_cnt_t mem [DEPTH];
  bht_cnt_t cur;
  bht_cnt_t nxt;

  // Reads see the pre-update value; no write bypass.
  assign rd_state = mem[rd_idx];
  assign cur      = mem[upd_idx];

  always_comb begin
    nxt = cur;
    case (cur)
      SNT: nxt = upd_taken ? WNT : SNT;
      WNT: nxt = upd_taken ? WT  : SNT;
      WT:  nxt = upd_taken ? ST  : WNT;
      ST:  nxt = upd_taken ? ST  : WT;
      default: nxt = BHT_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= BHT_RST;
    end else if (upd_en) begin
      mem[upd_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution unit with 2-bit BHT prediction and stats.
// Ports: fetch predict (pred_pc/pred_taken), resolve request
//        (res_valid_in, opcode, imm, rd, rs, pc, pred_taken_in),
//        registered result (res_valid, next_pc, taken, mispredict),
//        saturating counters (branch_cnt, mispred_cnt).
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int BHT_DEPTH     = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_WIDTH:0] pred_pc,
  output logic                   pred_taken,
  input  logic                   res_valid_in,
  input  logic [5:0]             opcode,
  input  logic [15:0]            imm,
  input  logic [DATA_WIDTH-1:0]  rd,
  input  logic [DATA_WIDTH-1:0]  rs,
  input  logic [ADDRESS_WIDTH:0] pc,
  input  logic                   pred_taken_in,
  output logic                   res_valid,
  output logic [ADDRESS_WIDTH:0] next_pc,
  output logic                   taken,
  output logic                   mispredict,
  output logic [CNT_WIDTH-1:0]   branch_cnt,
  output logic [CNT_WIDTH-1:0]   mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic                   accept;
  logic                   cond;
  logic                   mis;
  logic [1:0]             rd_state;
  logic [ADDRESS_WIDTH:0] tgt;

  assign accept = res_valid_in && is_branch(opcode);
  assign tgt    = imm[ADDRESS_WIDTH:0];
  assign mis    = cond != pred_taken_in;

  always_comb begin
    cond = 1'b0;
    case (opcode)
      OP_BEQ: cond = $signed(rd) == $signed(rs);
      OP_BNE: cond = $signed(rd) != $signed(rs);
      OP_BGT: cond = $signed(rd) >  $signed(rs);
      OP_BGE: cond = $signed(rd) >= $signed(rs);
      OP_BLT: cond = $signed(rd) <  $signed(rs);
      OP_BLE: cond = $signed(rd) <= $signed(rs);
      default: cond = 1'b0;
    endcase
  end

  bht_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pred_pc[IDX_W-1:0]),
    .rd_state  (rd_state),
    .upd_en    (accept),
    .upd_idx   (pc[IDX_W-1:0]),
    .upd_taken (cond)
  );

  assign pred_taken = rd_state[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      next_pc    <= '0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      res_valid  <= accept;
      mispredict <= accept && mis;
      if (accept) begin
        next_pc <= cond ? tgt : pc;
        taken   <= cond;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (accept) begin
      if (branch_cnt != '1)
        branch_cnt <= branch_cnt + 1'b1;
      if (mis && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit.
// A second instance with CNT_WIDTH=2 exercises counter saturation.
module tb_branch_predict_unit;
  import branch_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  pred_pc;
  logic        res_valid_in;
  logic [5:0]  opcode;
  logic [15:0] imm;
  logic [31:0] rd;
  logic [31:0] rs;
  logic [5:0]  pc;
  logic        pred_taken_in;

  logic        pred_taken;
  logic        res_valid;
  logic [5:0]  next_pc;
  logic        taken;
  logic        mispredict;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  logic        s_pred_taken;
  logic        s_res_valid;
  logic [5:0]  s_next_pc;
  logic        s_taken;
  logic        s_mispredict;
  logic [1:0]  s_branch_cnt;
  logic [1:0]  s_mispred_cnt;

  int n_chk;
  int n_fail;

  branch_predict_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .res_valid_in  (res_valid_in),
    .opcode        (opcode),
    .imm           (imm),
    .rd            (rd),
    .rs            (rs),
    .pc            (pc),
    .pred_taken_in (pred_taken_in),
    .res_valid     (res_valid),
    .next_pc       (next_pc),
    .taken         (taken),
    .mispredict    (mispredict),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  branch_predict_unit #(
    .CNT_WIDTH (2)
  ) dut_s (
    .clk           (clk),
    .rst           (rst),
    .pred_pc       (pred_pc),
    .pred_taken    (s_pred_taken),
    .res_valid_in  (res_valid_in),
    .opcode        (opcode),
    .imm           (imm),
    .rd            (rd),
    .rs            (rs),
    .pc            (pc),
    .pred_taken_in (pred_taken_in),
    .res_valid     (s_res_valid),
    .next_pc       (s_next_pc),
    .taken         (s_taken),
    .mispredict    (s_mispredict),
    .branch_cnt    (s_branch_cnt),
    .mispred_cnt   (s_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        vld;
    logic [5:0]  op;
    logic [31:0] rd;
    logic [31:0] rs;
    logic [15:0] imm;
    logic [5:0]  pc;
    logic        pti;
    logic        rv;
    logic [5:0]  npc;
    logic        tk;
    logic        mis;
  } vec_t;

  vec_t vt [10];

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [5:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [15:0] im,
    input logic [5:0]  p,
    input logic        pt
  );
    res_valid_in  = v;
    opcode        = op;
    rd            = a;
    rs            = b;
    imm           = im;
    pc            = p;
    pred_taken_in = pt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 32'd0, 32'd0,
          16'd0, 6'd0, 1'b0);
  endtask

  task automatic chk_out(
    input string      tag,
    input logic       rv,
    input logic [5:0] npc,
    input logic       tk,
    input logic       mi
  );
    chk({tag, ".res_valid"},  res_valid,  rv);
    chk({tag, ".next_pc"},    next_pc,    npc);
    chk({tag, ".taken"},      taken,      tk);
    chk({tag, ".mispredict"}, mispredict, mi);
  endtask

  task automatic chk_bht_reset(input string tag);
    logic any;
    any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pred_pc = 6'(i);
      #1;
      any = any | pred_taken;
    end
    chk({tag, ".bht_all_nt"}, any, 1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    pred_pc = '0;
    idle();

    // Reset with a request present: it must be dropped.
    rst = 1'b1;
    drive(1'b1, OP_BEQ, 32'd1, 32'd1,
          16'd9, 6'd1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    tick();
    chk_out("reset", 1'b0, 6'd0, 1'b0, 1'b0);
    chk("reset.branch_cnt",  branch_cnt,  16'd0);
    chk("reset.mispred_cnt", mispred_cnt, 16'd0);
    chk_bht_reset("reset");

    // beq 5==5, predicted not taken.
    drive(1'b1, OP_BEQ, 32'd5, 32'd5,
          16'h0014, 6'd3, 1'b0);
    tick();
    chk_out("beq1", 1'b1, 6'd20, 1'b1, 1'b1);
    chk("beq1.branch_cnt",  branch_cnt,  16'd1);
    chk("beq1.mispred_cnt", mispred_cnt, 16'd1);

    // Idle cycle: hold next_pc/taken, clear pulses.
    drive(1'b0, OP_BEQ, 32'd1, 32'd2,
          16'd3, 6'd4, 1'b1);
    tick();
    chk_out("idle", 1'b0, 6'd20, 1'b1, 1'b0);

    vt[0] = '{1'b1, OP_BLT, 32'hFFFF_FFFF, 32'd0,
              16'd7, 6'd2, 1'b1,
              1'b1, 6'd7, 1'b1, 1'b0};
    vt[1] = '{1'b1, OP_BGT, 32'hFFFF_FFFF, 32'd0,
              16'd7, 6'd2, 1'b1,
              1'b1, 6'd2, 1'b0, 1'b1};
    vt[2] = '{1'b1, OP_BGE, 32'd5, 32'd5,
              16'h001F, 6'd1, 1'b0,
              1'b1, 6'd31, 1'b1, 1'b1};
    vt[3] = '{1'b1, OP_BLE, 32'd6, 32'd5,
              16'd9, 6'd8, 1'b0,
              1'b1, 6'd8, 1'b0, 1'b0};
    vt[4] = '{1'b1, OP_BNE, 32'd1, 32'd2,
              16'hFFE5, 6'd9, 1'b1,
              1'b1, 6'd37, 1'b1, 1'b0};
    vt[5] = '{1'b1, OP_BEQ, 32'd3, 32'd4,
              16'd5, 6'h3F, 1'b1,
              1'b1, 6'd63, 1'b0, 1'b1};
    vt[6] = '{1'b1, 6'b000000, 32'd1, 32'd1,
              16'd1, 6'd1, 1'b0,
              1'b0, 6'd63, 1'b0, 1'b0};
    vt[7] = '{1'b1, OP_BGE, 32'hFFFF_FFFB,
              32'hFFFF_FFFD, 16'd12, 6'd11, 1'b0,
              1'b1, 6'd11, 1'b0, 1'b0};
    vt[8] = '{1'b1, OP_BLE, 32'h8000_0000, 32'd1,
              16'd13, 6'd12, 1'b0,
              1'b1, 6'd13, 1'b1, 1'b1};
    vt[9] = '{1'b1, 6'b001110, 32'd1, 32'd1,
              16'd2, 6'd14, 1'b0,
              1'b0, 6'd13, 1'b1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].vld, vt[i].op, vt[i].rd,
            vt[i].rs, vt[i].imm, vt[i].pc,
            vt[i].pti);
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].rv,
              vt[i].npc, vt[i].tk, vt[i].mis);
    end
    idle();
    tick();
    chk("tbl.branch_cnt",    branch_cnt,    16'd9);
    chk("tbl.mispred_cnt",   mispred_cnt,   16'd5);
    chk("tbl.s_branch_cnt",  s_branch_cnt,  2'd3);
    chk("tbl.s_mispred_cnt", s_mispred_cnt, 2'd3);

    // Non-branch opcode on pc=4: no stats, no BHT change.
    pred_pc = 6'd4;
    drive(1'b1, 6'b000000, 32'd1, 32'd1,
          16'd2, 6'd4, 1'b0);
    tick();
    chk("nb.res_valid",   res_valid,   1'b0);
    chk("nb.branch_cnt",  branch_cnt,  16'd9);
    chk("nb.mispred_cnt", mispred_cnt, 16'd5);
    chk("nb.pred4",       pred_taken,  1'b0);

    // Three taken on entry 4: 01->10->11->11.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_BEQ, 32'd1, 32'd1,
            16'd2, 6'd4, 1'b0);
      tick();
      chk($sformatf("tr%0d.pred4", i),
          pred_taken, 1'b1);
    end
    // Two not-taken: 11->10 (still T), 10->01.
    drive(1'b1, OP_BEQ, 32'd1, 32'd2,
          16'd2, 6'd4, 1'b1);
    tick();
    chk("sat.pred4_a", pred_taken, 1'b1);
    tick();
    chk("sat.pred4_b", pred_taken, 1'b0);

    // Entry 6 to weak-T, then read during NT update.
    pred_pc = 6'd6;
    drive(1'b1, OP_BEQ, 32'd1, 32'd1,
          16'd2, 6'd6, 1'b0);
    tick();
    drive(1'b1, OP_BEQ, 32'd1, 32'd2,
          16'd2, 6'd6, 1'b1);
    #1;
    chk("rw.pred_same", pred_taken, 1'b1);
    tick();
    chk("rw.pred_next", pred_taken, 1'b0);

    // Entry 1 was trained taken by vec2.
    pred_pc = 6'd1;
    #1;
    chk("pre_rst.pred1", pred_taken, 1'b1);

    // Reset mid-stream with a mispredicting request.
    rst = 1'b1;
    drive(1'b1, OP_BEQ, 32'd1, 32'd1,
          16'd9, 6'd1, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    chk_out("mrst", 1'b0, 6'd0, 1'b0, 1'b0);
    chk("mrst.branch_cnt",    branch_cnt,    16'd0);
    chk("mrst.mispred_cnt",   mispred_cnt,   16'd0);
    chk("mrst.s_mispred_cnt", s_mispred_cnt, 2'd0);
    chk_bht_reset("mrst");

    // One taken on entry 1 must flip it (01, not 00).
    pred_pc = 6'd1;
    drive(1'b1, OP_BEQ, 32'd2, 32'd2,
          16'd9, 6'd1, 1'b1);
    tick();
    chk("mrst.pred1", pred_taken, 1'b1);

    // Five mispredicts: small counters stop at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_BNE, 32'd7, 32'd7,
            16'd9, 6'd10, 1'b1);
      tick();
    end
    idle();
    chk("sat.mispredict",    mispredict,    1'b1);
    chk("sat.s_mispred_cnt", s_mispred_cnt, 2'd3);
    chk("sat.s_branch_cnt",  s_branch_cnt,  2'd3);
    chk("sat.mispred_cnt",   mispred_cnt,   16'd5);
    chk("sat.branch_cnt",    branch_cnt,    16'd6);
    tick();
    chk("sat.s_mispred_hold", s_mispred_cnt, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
